// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: FSM state encoding and default score width.
package pong_pkg;

  localparam int SCORE_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } pong_state_e;

endpackage

// File: rtl/pong_game_sequencer_if.sv
// Control/status bundle between the game sequencer, the player inputs and the pong datapath.
interface pong_game_sequencer_if
  import pong_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);

  // No valid/ready pairs: start/pause are levels sampled every rising edge, misses are
  // sampled every unpaused PLAY cycle, and step/serve are single-cycle registered strobes.
  logic               start;
  logic               pause;
  logic               miss_left;
  logic               miss_right;
  logic               step;
  logic               serve;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  pong_state_e        state;
  logic               game_over;

  modport master (
    output start, pause, miss_left, miss_right,
    input  step, serve, serve_dir, score_left, score_right, state, game_over
  );

  modport slave (
    input  start, pause, miss_left, miss_right,
    output step, serve, serve_dir, score_left, score_right, state, game_over
  );

endinterface

// File: rtl/pong_tick_gen.sv
// Game-step divider: cnt runs 0..TICK_DIV-1, freezes on pause, and is zeroed by clear.
module pong_tick_gen #(
  parameter int TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !pause;

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game-flow FSM: serve countdown, step strobes, miss scoring and game-over detection.
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 16,
  parameter int SERVE_DELAY = 8,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pong_game_sequencer_if.slave  bus
);

  localparam int                 SRV_W    = $clog2(SERVE_DELAY + 1);
  localparam logic [SRV_W-1:0]   SRV_LOAD = SRV_W'(SERVE_DELAY);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  pong_state_e        st;
  logic [SRV_W-1:0]   srv_cnt;
  logic [SCORE_W-1:0] score_l, score_r;
  logic [SCORE_W-1:0] inc_l, inc_r;
  logic               step_q, serve_q, dir_q, over_q;
  logic               tick, clear;
  logic               start_go, serve_go, miss_any;

  // Every state change restarts the step timer, so these mirror the FSM's transition terms.
  assign start_go = ((st == ST_IDLE) || (st == ST_OVER)) && bus.start;
  assign serve_go = (st == ST_SERVE) && tick && (srv_cnt == SRV_W'(1));
  assign miss_any = (st == ST_PLAY) && !bus.pause && (bus.miss_left || bus.miss_right);
  assign clear    = start_go || serve_go || miss_any;

  assign inc_l = score_l + SCORE_W'(1);
  assign inc_r = score_r + SCORE_W'(1);

  pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .pause (bus.pause),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      srv_cnt <= '0;
      score_l <= '0;
      score_r <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      serve_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      serve_q <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (start_go) begin
            st      <= ST_SERVE;
            srv_cnt <= SRV_LOAD;
            score_l <= '0;
            score_r <= '0;
            over_q  <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (tick) begin
            srv_cnt <= srv_cnt - SRV_W'(1);
            if (serve_go) begin
              serve_q <= 1'b1;
              st      <= ST_PLAY;
            end
          end
        end
        ST_PLAY: begin
          // A miss outranks a coincident tick, so no step is issued on that edge.
          if (miss_any) begin
            if (bus.miss_left && bus.miss_right) begin
              dir_q   <= ~dir_q;
              st      <= ST_SERVE;
              srv_cnt <= SRV_LOAD;
            end else if (bus.miss_left) begin
              score_r <= inc_r;
              dir_q   <= 1'b0;
              if (inc_r == WIN) begin
                st     <= ST_OVER;
                over_q <= 1'b1;
              end else begin
                st      <= ST_SERVE;
                srv_cnt <= SRV_LOAD;
              end
            end else begin
              score_l <= inc_l;
              dir_q   <= 1'b1;
              if (inc_l == WIN) begin
                st     <= ST_OVER;
                over_q <= 1'b1;
              end else begin
                st      <= ST_SERVE;
                srv_cnt <= SRV_LOAD;
              end
            end
          end else if (tick) begin
            step_q <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.state       = st;
  assign bus.step        = step_q;
  assign bus.serve       = serve_q;
  assign bus.serve_dir   = dir_q;
  assign bus.score_left  = score_l;
  assign bus.score_right = score_r;
  assign bus.game_over   = over_q;

endmodule
